// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, the starting position and the
// default board/sprite geometry used by the sprite scheduler.
package chess_pkg;

  typedef enum logic [3:0] {
    EMPTY    = 4'd0,
    W_PAWN   = 4'd1,
    W_KNIGHT = 4'd2,
    W_BISHOP = 4'd3,
    W_ROOK   = 4'd4,
    W_QUEEN  = 4'd5,
    W_KING   = 4'd6,
    B_PAWN   = 4'd9,
    B_KNIGHT = 4'd10,
    B_BISHOP = 4'd11,
    B_ROOK   = 4'd12,
    B_QUEEN  = 4'd13,
    B_KING   = 4'd14
  } piece_t;

  localparam int SQ_DEF  = 60;
  localparam int SPR_DEF = 55;
  localparam int PAD_DEF = 2;

  // Starting position, index = row*8+col with row 0 (black) at the top.
  localparam logic [3:0] INIT_BOARD [64] = '{
    B_ROOK, B_KNIGHT, B_BISHOP, B_QUEEN, B_KING, B_BISHOP, B_KNIGHT, B_ROOK,
    B_PAWN, B_PAWN,   B_PAWN,   B_PAWN,  B_PAWN, B_PAWN,   B_PAWN,   B_PAWN,
    EMPTY,  EMPTY,    EMPTY,    EMPTY,   EMPTY,  EMPTY,    EMPTY,    EMPTY,
    EMPTY,  EMPTY,    EMPTY,    EMPTY,   EMPTY,  EMPTY,    EMPTY,    EMPTY,
    EMPTY,  EMPTY,    EMPTY,    EMPTY,   EMPTY,  EMPTY,    EMPTY,    EMPTY,
    EMPTY,  EMPTY,    EMPTY,    EMPTY,   EMPTY,  EMPTY,    EMPTY,    EMPTY,
    W_PAWN, W_PAWN,   W_PAWN,   W_PAWN,  W_PAWN, W_PAWN,   W_PAWN,   W_PAWN,
    W_ROOK, W_KNIGHT, W_BISHOP, W_QUEEN, W_KING, W_BISHOP, W_KNIGHT, W_ROOK
  };

  // Codes outside the defined piece set are drawn as an empty square.
  function automatic logic [3:0] render_code(input logic [3:0] code);
    logic [3:0] res;
    res = EMPTY;
    if ((code >= 4'd1 && code <= 4'd6) || (code >= 4'd9 && code <= 4'd14)) begin
      res = code;
    end
    return res;
  endfunction

endpackage

// File: rtl/board_regfile.sv
// 64x4 board storage: one combinational read port, one write port and a
// synchronous reload of the starting position (reset also loads it).
module board_regfile
  import chess_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_init,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [3:0] wdata,
  input  logic [5:0] raddr,
  output logic [3:0] rdata
);

  logic [3:0] mem_q [64];
  logic [3:0] mem_d [64];

  // Next board: a new-game reload takes priority over a single-square write.
  always_comb begin
    mem_d = mem_q;
    if (load_init) begin
      for (int i = 0; i < 64; i++) begin
        mem_d[i] = INIT_BOARD[i];
      end
    end else if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Board registers, restored to the starting position on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        mem_q[i] <= INIT_BOARD[i];
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/board_sprite_sched.sv
// Per-pixel chessboard scheduler: tracks the square under the beam with
// counters, looks up the piece there and produces the sprite ROM address,
// sprite/board flags and square colour two cycles after the pixel.
module board_sprite_sched
  import chess_pkg::*;
#(
  parameter int BOARD_X0 = 80,
  parameter int BOARD_Y0 = 0,
  parameter int SQ       = SQ_DEF,
  parameter int SPR      = SPR_DEF,
  parameter int PAD      = PAD_DEF
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        new_game,
  input  logic        upd_valid,
  input  logic [5:0]  upd_square,
  input  logic [3:0]  upd_piece,
  output logic        upd_ready,
  output logic [3:0]  piece_sel,
  output logic [11:0] rom_address,
  output logic        sprite_on,
  output logic        in_board,
  output logic        sq_dark
);

  // Position counters (col/row == 8 means outside the board).
  logic [5:0] locx_q, locx_d, locy_q, locy_d;
  logic [3:0] col_q, col_d, row_q, row_d;

  // Stage 1 registers.
  logic [5:0] sq_s1_q, locx_s1_q, locy_s1_q;
  logic       win_s1_q, dark_s1_q;

  // Stage 2 (output) next values.
  logic [3:0]  piece_sel_d;
  logic [11:0] rom_address_d;
  logic        sprite_on_d, in_board_d, sq_dark_d;

  logic [3:0]  rd_piece;
  logic [3:0]  piece;
  logic        upd_we;
  logic [11:0] off_x, off_y;
  logic        x_in_spr, y_in_spr;

  // Writes are only taken during vertical blank, and a new game blocks them.
  assign upd_ready = (DrawY >= 10'd480) && !new_game;
  assign upd_we    = upd_valid && upd_ready;

  board_regfile u_board (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .load_init (new_game),
    .we        (upd_we),
    .waddr     (upd_square),
    .wdata     (upd_piece),
    .raddr     (sq_s1_q),
    .rdata     (rd_piece)
  );

  // Column counter steps every pixel; row counter steps once per line at DrawX==0.
  always_comb begin
    locx_d = locx_q;
    col_d  = col_q;
    locy_d = locy_q;
    row_d  = row_q;
    if (DrawX == 10'(BOARD_X0)) begin
      locx_d = '0;
      col_d  = '0;
    end else if (!col_q[3]) begin
      if (locx_q == 6'(SQ - 1)) begin
        locx_d = '0;
        col_d  = col_q + 4'd1;
      end else begin
        locx_d = locx_q + 6'd1;
      end
    end
    if (DrawX == 10'd0) begin
      if (DrawY == 10'(BOARD_Y0)) begin
        locy_d = '0;
        row_d  = '0;
      end else if (!row_q[3]) begin
        if (locy_q == 6'(SQ - 1)) begin
          locy_d = '0;
          row_d  = row_q + 4'd1;
        end else begin
          locy_d = locy_q + 6'd1;
        end
      end
    end
  end

  // Output stage: piece lookup, sprite window test and ROM address.
  always_comb begin
    piece    = render_code(rd_piece);
    x_in_spr = (locx_s1_q >= 6'(PAD)) && (locx_s1_q <= 6'(PAD + SPR - 1));
    y_in_spr = (locy_s1_q >= 6'(PAD)) && (locy_s1_q <= 6'(PAD + SPR - 1));
    off_x    = 12'(locx_s1_q) - 12'(PAD);
    off_y    = 12'(locy_s1_q) - 12'(PAD);

    in_board_d    = win_s1_q;
    sq_dark_d     = dark_s1_q;
    piece_sel_d   = win_s1_q ? piece : 4'(EMPTY);
    sprite_on_d   = win_s1_q && (piece != 4'(EMPTY)) && x_in_spr && y_in_spr;
    rom_address_d = sprite_on_d ? (off_x + off_y * 12'(SPR)) : 12'd0;
  end

  // Counters, stage 1 and output registers; reset clears the pipeline at once.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      locx_q      <= '0;
      locy_q      <= '0;
      col_q       <= 4'd8;
      row_q       <= 4'd8;
      sq_s1_q     <= '0;
      locx_s1_q   <= '0;
      locy_s1_q   <= '0;
      win_s1_q    <= 1'b0;
      dark_s1_q   <= 1'b0;
      piece_sel   <= '0;
      rom_address <= '0;
      sprite_on   <= 1'b0;
      in_board    <= 1'b0;
      sq_dark     <= 1'b0;
    end else begin
      locx_q      <= locx_d;
      locy_q      <= locy_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sq_s1_q     <= {row_q[2:0], col_q[2:0]};
      locx_s1_q   <= locx_q;
      locy_s1_q   <= locy_q;
      win_s1_q    <= !col_q[3] && !row_q[3];
      dark_s1_q   <= row_q[0] ^ col_q[0];
      piece_sel   <= piece_sel_d;
      rom_address <= rom_address_d;
      sprite_on   <= sprite_on_d;
      in_board    <= in_board_d;
      sq_dark     <= sq_dark_d;
    end
  end

endmodule

// File: tb/tb_board_sprite_sched.sv
// Directed testbench for board_sprite_sched: scans chosen pixels through a
// compressed raster and checks the scheduler outputs against hand values.
module tb_board_sprite_sched;

  logic        vga_clk;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        new_game, upd_valid;
  logic [5:0]  upd_square;
  logic [3:0]  upd_piece;
  logic        upd_ready;
  logic [3:0]  piece_sel;
  logic [11:0] rom_address;
  logic        sprite_on, in_board, sq_dark;

  int tests = 0;
  int fails = 0;

  board_sprite_sched dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .new_game    (new_game),
    .upd_valid   (upd_valid),
    .upd_square  (upd_square),
    .upd_piece   (upd_piece),
    .upd_ready   (upd_ready),
    .piece_sel   (piece_sel),
    .rom_address (rom_address),
    .sprite_on   (sprite_on),
    .in_board    (in_board),
    .sq_dark     (sq_dark)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // One DrawX==0 cycle per line up to y, then DrawX from 80 to x, then two
  // more cycles so the outputs for (x,y) are visible.
  task automatic goto_px(input int x, input int y);
    for (int yy = 0; yy <= y; yy++) begin
      DrawX = 10'd0; DrawY = 10'(yy); step();
    end
    for (int xx = 80; xx <= x + 2; xx++) begin
      DrawX = 10'(xx); step();
    end
    $display("[TB] pixel (%0d,%0d): in_board=%0d dark=%0d piece=%0d spr=%0d rom=%0d",
             x, y, in_board, sq_dark, piece_sel, sprite_on, rom_address);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    new_game = 1'b0; upd_valid = 1'b0; upd_square = 6'd0; upd_piece = 4'd0;
    step(); step();
    tests++;
    if ({in_board, sq_dark, sprite_on, piece_sel, rom_address} !== 19'd0) begin
      fails++;
      $display("FAIL reset_outputs: got in=%0d dark=%0d spr=%0d piece=%0d rom=%0d, expected all 0",
               in_board, sq_dark, sprite_on, piece_sel, rom_address);
    end
    tests++;
    if (upd_ready !== 1'b0) begin
      fails++; $display("FAIL reset_upd_ready: got %0d expected 0", upd_ready);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_geometry();
    goto_px(80, 0);
    tests++;
    if ({in_board, sq_dark, piece_sel, sprite_on} !== {1'b1, 1'b0, 4'd12, 1'b0}) begin
      fails++;
      $display("FAIL px80_0: got in=%0d dark=%0d piece=%0d spr=%0d expected 1 0 12 0",
               in_board, sq_dark, piece_sel, sprite_on);
    end
    goto_px(82, 2);
    tests++;
    if ({sprite_on, rom_address} !== {1'b1, 12'd0}) begin
      fails++; $display("FAIL px82_2: got spr=%0d rom=%0d expected 1 0", sprite_on, rom_address);
    end
    goto_px(136, 56);
    tests++;
    if ({sprite_on, rom_address} !== {1'b1, 12'd3024}) begin
      fails++; $display("FAIL px136_56: got spr=%0d rom=%0d expected 1 3024", sprite_on, rom_address);
    end
    goto_px(137, 57);
    tests++;
    if ({in_board, sprite_on, rom_address} !== {1'b1, 1'b0, 12'd0}) begin
      fails++;
      $display("FAIL px137_57: got in=%0d spr=%0d rom=%0d expected 1 0 0", in_board, sprite_on, rom_address);
    end
    goto_px(139, 0);
    tests++;
    if ({in_board, piece_sel} !== {1'b1, 4'd12}) begin
      fails++; $display("FAIL px139_0: got in=%0d piece=%0d expected 1 12", in_board, piece_sel);
    end
    goto_px(140, 0);
    tests++;
    if ({piece_sel, sq_dark, sprite_on} !== {4'd10, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL px140_0: got piece=%0d dark=%0d spr=%0d expected 10 1 0", piece_sel, sq_dark, sprite_on);
    end
    goto_px(320, 460);
    tests++;
    if ({piece_sel, sq_dark, sprite_on} !== {4'd6, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL px320_460: got piece=%0d dark=%0d spr=%0d expected 6 1 0", piece_sel, sq_dark, sprite_on);
    end
    goto_px(559, 100);
    tests++;
    if ({in_board, piece_sel} !== {1'b1, 4'd9}) begin
      fails++; $display("FAIL px559_100: got in=%0d piece=%0d expected 1 9", in_board, piece_sel);
    end
    goto_px(560, 100);
    tests++;
    if ({in_board, piece_sel, sprite_on} !== {1'b0, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL px560_100: got in=%0d piece=%0d spr=%0d expected 0 0 0", in_board, piece_sel, sprite_on);
    end
  endtask

  task automatic test_update();
    upd_valid = 1'b1; upd_square = 6'd52; upd_piece = 4'd5;
    DrawX = 10'd0; DrawY = 10'd200; #1;
    tests++;
    if (upd_ready !== 1'b0) begin
      fails++; $display("FAIL upd_ready_active: got %0d expected 0", upd_ready);
    end
    goto_px(340, 380);
    tests++;
    if ({piece_sel, sprite_on, rom_address} !== {4'd1, 1'b1, 12'd1008}) begin
      fails++;
      $display("FAIL sq52_before: got piece=%0d spr=%0d rom=%0d expected 1 1 1008",
               piece_sel, sprite_on, rom_address);
    end
    DrawX = 10'd0; DrawY = 10'd480; #1;
    tests++;
    if (upd_ready !== 1'b1) begin
      fails++; $display("FAIL upd_ready_vblank: got %0d expected 1", upd_ready);
    end
    step();
    $display("[TB] write sq=52 piece=5 in vblank");
    upd_square = 6'd20; upd_piece = 4'd15;
    step();
    $display("[TB] write sq=20 piece=15 in vblank");
    upd_valid = 1'b0;
    goto_px(340, 380);
    tests++;
    if ({piece_sel, sprite_on, rom_address, sq_dark} !== {4'd5, 1'b1, 12'd1008, 1'b0}) begin
      fails++;
      $display("FAIL sq52_after: got piece=%0d spr=%0d rom=%0d dark=%0d expected 5 1 1008 0",
               piece_sel, sprite_on, rom_address, sq_dark);
    end
    goto_px(340, 140);
    tests++;
    if ({in_board, piece_sel, sprite_on} !== {1'b1, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL sq20_invalid: got in=%0d piece=%0d spr=%0d expected 1 0 0", in_board, piece_sel, sprite_on);
    end
  endtask

  task automatic test_new_game();
    DrawX = 10'd0; DrawY = 10'd490;
    upd_valid = 1'b1; upd_square = 6'd0; upd_piece = 4'd5; new_game = 1'b1; #1;
    tests++;
    if (upd_ready !== 1'b0) begin
      fails++; $display("FAIL upd_ready_newgame: got %0d expected 0", upd_ready);
    end
    step();
    $display("[TB] new_game with write sq=0 piece=5");
    new_game = 1'b0; upd_valid = 1'b0;
    goto_px(340, 380);
    tests++;
    if (piece_sel !== 4'd1) begin
      fails++; $display("FAIL newgame_sq52: got %0d expected 1", piece_sel);
    end
    goto_px(100, 20);
    tests++;
    if (piece_sel !== 4'd12) begin
      fails++; $display("FAIL newgame_sq0: got %0d expected 12", piece_sel);
    end
    goto_px(340, 140);
    tests++;
    if (piece_sel !== 4'd0) begin
      fails++; $display("FAIL newgame_sq20: got %0d expected 0", piece_sel);
    end
  endtask

  task automatic test_midframe_reset();
    DrawX = 10'd0; DrawY = 10'd500;
    upd_valid = 1'b1; upd_square = 6'd52; upd_piece = 4'd5;
    step();
    upd_valid = 1'b0;
    goto_px(340, 380);
    tests++;
    if ({piece_sel, sprite_on} !== {4'd5, 1'b1}) begin
      fails++; $display("FAIL prereset_sq52: got piece=%0d spr=%0d expected 5 1", piece_sel, sprite_on);
    end
    reset_n = 1'b0; #1;
    tests++;
    if ({in_board, sq_dark, sprite_on, piece_sel, rom_address} !== 19'd0) begin
      fails++;
      $display("FAIL midframe_reset: got in=%0d dark=%0d spr=%0d piece=%0d rom=%0d expected all 0",
               in_board, sq_dark, sprite_on, piece_sel, rom_address);
    end
    step(); step();
    reset_n = 1'b1;
    step();
    goto_px(340, 380);
    tests++;
    if ({piece_sel, sprite_on, rom_address} !== {4'd1, 1'b1, 12'd1008}) begin
      fails++;
      $display("FAIL postreset_sq52: got piece=%0d spr=%0d rom=%0d expected 1 1 1008",
               piece_sel, sprite_on, rom_address);
    end
    goto_px(80, 0);
    tests++;
    if ({in_board, piece_sel} !== {1'b1, 4'd12}) begin
      fails++; $display("FAIL postreset_sq0: got in=%0d piece=%0d expected 1 12", in_board, piece_sel);
    end
  endtask

  initial begin
    test_reset();
    test_geometry();
    test_update();
    test_new_game();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/board_sprite_sched.md
# board_sprite_sched

Per-pixel scheduler that sequences the shared piece-sprite datapath for the 8x8 chessboard. It tracks DrawX/DrawY with counters rather than dividers, holds the 64-square board state, and selects the piece sprite to show at each pixel. It also emits the sprite-local ROM address and the square colour. It sits between the VGA controller and the piece ROM/palette bank, and it accepts board updates from game logic only during vertical blank.

## Interface
- BOARD_X0, 80: left pixel column of the board.
- BOARD_Y0, 0: top pixel row of the board.
- SQ, 60: square edge in pixels.
- SPR, 55: sprite edge in pixels.
- PAD, 2: sprite inset from the square's top-left corner.
- vga_clk  in  1  pixel clock; DrawX advances by one per cycle.
- reset_n  in  1  reset, asynchronous and active-low.
- DrawX, DrawY  in  10 each  current pixel coordinates from the VGA controller.
- new_game  in  1  one-cycle pulse that restores the initial position.
- upd_valid  in  1  board write request.
- upd_square  in  6  target square, index = row*8+col, row 0 at the top.
- upd_piece  in  4  piece code to write.
- upd_ready  out  1  write accepted when upd_valid && upd_ready.
- piece_sel  out  4  piece code that selects the ROM/palette pair.
- rom_address  out  12  sprite-local address.
- sprite_on  out  1  a piece pixel is present at this position.
- in_board  out  1  pixel lies inside the board.
- sq_dark  out  1  square is a dark square.

## Operation
- Piece codes: 0 EMPTY; 1–6 white P,N,B,R,Q,K; 9–14 black P,N,B,R,Q,K. Other codes render as EMPTY.
- Column tracking, one cycle per pixel:
  - DrawX==BOARD_X0: locx=0, col=0.
  - Otherwise, if col<8: when locx==SQ-1, locx=0 and col++; else locx++.
  - col==8 means out of board; it holds until the next BOARD_X0.
- Row tracking, evaluated only on the cycle DrawX==0:
  - DrawY==BOARD_Y0: locy=0, row=0.
  - Otherwise, if row<8: when locy==SQ-1, locy=0 and row++; else locy++.
  - row==8 saturates.
- Stage 1 registers the square index, locx, locy, and an in-window flag (col<8 && row<8).
- Stage 2 registers outputs from the board array read:
  - in_board = in-window flag.
  - sq_dark = row[0]^col[0].
  - piece_sel = board[square], or 0 if not in_board.
  - sprite_on = in_board && piece≠EMPTY && PAD≤locx≤PAD+SPR-1 && PAD≤locy≤PAD+SPR-1.
  - rom_address = (locx-PAD)+(locy-PAD)*SPR when sprite_on, else 0. Unsigned, maximum 3024, fits 12 bits.
- Board array is 64×4 registers. Reset and new_game both load the initial position:
  - Row 0: black R N B Q K B N R.
  - Row 1: black P.
  - Rows 2–5: EMPTY.
  - Row 6: white P.
  - Row 7: white R N B Q K B N R.
- Update port:
  - upd_ready = (DrawY≥480) && !new_game.
  - An accepted write lands at the next clock edge.
  - new_game in the same cycle as upd_valid wins, and the write is not accepted.
  - upd_valid may stay high across active video; it simply waits.

## Timing
- Reset values: all outputs 0, counters 0 with col=row=8, board = initial position.
- Reset asserted mid-frame clears the pipeline immediately. Board state is valid from the first edge after release.
- Latency: DrawX/DrawY sampled at edge N → outputs valid after edge N+2. The sprite ROM adds one more cycle (negedge read, posedge colour), so downstream compositing delays the board colour to match.
- A write accepted at edge K is visible to reads from edge K+1. Because writes happen only in vblank, the board never changes mid-frame.
- Boundaries:
  - Last pixel column of a square (locx=SQ-1) wraps to the next column.
  - The pixel after column 7, locx=SQ-1 is out of board.
  - DrawX=BOARD_X0+8*SQ = 560 yields in_board=0.

## Structure
- Package chess_pkg holds:
  - the piece_t enum (4-bit codes above);
  - the EMPTY constant;
  - the INIT_BOARD constant array;
  - the SQ/SPR/PAD defaults.
- Sub-module board_regfile: 64×4 storage, one combinational read port, one write port, synchronous load of INIT_BOARD.
- Counters and pipeline stay in the top block.

## Test plan
- Reset then sweep frame: pixel (80,0), square 0 → after 2 cycles in_board=1, sq_dark=0, piece_sel=black R, sprite_on=0 (locx=0<PAD).
- Pixel (82,2) → sprite_on=1, rom_address=0. Pixel (136,56) → rom_address=54+54*55=3024.
- Pixel (140,0) → col=1 black N, sq_dark=1. Pixel (560,100) → in_board=0, piece_sel=0, sprite_on=0.
- upd_valid during DrawY=200 → upd_ready=0, no write. Held until DrawY=480 → accepted; the next frame shows square 52 = white Q.
- new_game together with upd_valid in vblank → upd_ready=0, board equals initial position.
- Assert reset_n low at pixel (300,300) → outputs 0 within the same cycle; after release, the first valid frame is correct.
